shift_deserializer: RTL
=======================

// Module: shift_deserializer
// PURPOSE
//  Serial-to-parallel receiver. It assembles N bits from a qualified serial bit
//  stream into one word and presents that word on a valid/ready output port.
//  It is the receive end of the serial link that our shift registers drive in
//  shift-left (MSB-first) or shift-right (LSB-first) mode. A one-word output
//  buffer gives the downstream logic one full word time to accept each word.
// PARAMETERS
//  N   8   Word width in bits. Minimum value is 2.
// PORTS
//  i_clk          in   1  System clock. All logic is on the rising edge.
//  i_rst          in   1  Reset. Synchronous and active-high.
//  i_bit_valid    in   1  Qualifies i_bit. One bit is accepted on each edge where this is 1.
//  i_bit          in   1  Serial data bit.
//  i_lsb_first    in   1  0 = MSB first (shift left); 1 = LSB first (shift right).
//  i_frame_start  in   1  Discards any partial word and realigns word boundaries.
//  i_clr_ovr      in   1  Clears the sticky o_overrun flag.
//  o_data         out  N  Assembled word. Stable while o_valid=1.
//  o_valid        out  1  Output buffer holds a word.
//  i_ready        in   1  Downstream accepts o_data on an edge where o_valid & i_ready.
//  o_busy         out  1  A partial word is in progress (bit count is not 0).
//  o_overrun      out  1  Sticky. A completed word was dropped because the buffer was full.
// BEHAVIOUR
//  Reset (i_rst=1 at an edge): shift register=0, bit count=0, state=IDLE,
//   o_data=0, o_valid=0, o_busy=0, o_overrun=0. i_rst overrides every other input.
//  Receive FSM has two states:
//   IDLE -> RECV on an accepted bit.
//   RECV -> IDLE when the Nth bit is accepted or when i_frame_start=1.
//  Bit acceptance: on an edge with i_bit_valid=1, the shift register is updated.
//   MSB first: next = {shreg[N-2:0], i_bit}
//   LSB first: next = {i_bit, shreg[N-1:1]}
//   The bit count increments by 1, range 0..N-1, and wraps to 0 after the Nth bit.
//   Edges with i_bit_valid=0 leave the shift register and count unchanged.
//   Gaps between bits of any length are allowed.
//  Direction is sampled on the first bit of each word (count=0) and held for the
//   rest of that word. A change of i_lsb_first in mid-word has no effect until the next word.
//  Word completion happens on the edge that accepts the Nth bit:
//   - The completed word is the shift-register next value.
//   - If o_valid=0, or o_valid & i_ready on the same edge, o_data <= word and
//     o_valid <= 1 on that edge. Latency is 0 cycles after the last-bit edge.
//   - Otherwise the word is dropped, o_overrun <= 1, and o_data is unchanged.
//  Output handshake:
//   - o_valid falls on an edge with o_valid & i_ready, unless a new word loads on that same edge.
//   - o_data and o_valid never change while o_valid=1 and i_ready=0, except under i_rst.
//  i_frame_start=1: count <= 0 and the partial word is discarded. The output buffer is untouched.
//   If i_bit_valid=1 on the same edge, that bit is accepted as bit 1 of a new word,
//   with count <= 1 and direction sampled on that edge.
//  o_overrun: set as above and held until i_clr_ovr or i_rst.
//   If set and clear happen on the same edge, set wins.
//  o_busy = (count != 0). It is registered state, not a separate flop.
//  Reset mid-word discards all progress. The first bit after reset is bit 1 of a word.
// TESTING (N=8)
//  1. MSB first, i_ready=1, bits 1,1,0,1,0,0,0,0 on consecutive cycles
//     -> o_data=0xD0, o_valid=1 on the 8th-bit edge, low one edge later.
//  2. LSB first, same bit stream -> o_data=0x0B. Toggling i_lsb_first at bit 4 -> still 0x0B.
//  3. i_ready=0, send 0x12 then 0x34 MSB first -> o_data stays 0x12, o_overrun=1.
//     Then i_ready=1 -> 0x12 drained, o_valid=0. Pulse i_clr_ovr -> o_overrun=0.
//  4. 3 bits (1,0,1), then i_frame_start together with the first bit of 0x5A,
//     then the remaining 7 bits -> o_data=0x5A, with no word emitted for the 3 stray bits.
//  5. Bits of 0xC3 with random 0-5 cycle gaps between them -> o_data=0xC3.
//     o_busy=1 from bit 1 through bit 7, 0 after bit 8.
//  6. i_rst after 5 bits, then a full 0x81 -> o_data=0x81, no overrun.
//     A word completing on the same edge as o_valid&i_ready drain -> new word loaded, o_valid stays 1.

Source files
------------

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: collects N qualified bits into a word (MSB- or LSB-first)
// and presents it through a one-word valid/ready output buffer with a sticky overrun flag.
module shift_deserializer #(
    parameter int unsigned N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_bit_valid,
    input  logic         i_bit,
    input  logic         i_lsb_first,
    input  logic         i_frame_start,
    input  logic         i_clr_ovr,
    output logic [N-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_busy,
    output logic         o_overrun
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_shreg;
    logic [N-1:0]  r_data;
    logic [CW-1:0] r_count;
    logic          r_dir;
    logic          r_valid;
    logic          r_overrun;

    logic          w_first;
    logic          w_dir;
    logic [N-1:0]  w_base;
    logic [N-1:0]  w_next;
    logic          w_last;
    logic          w_drain;
    logic          w_load;
    logic          w_drop;

    // Direction is latched on the first bit of a word (IDLE, or a realigning frame start).
    assign w_first = (r_state == IDLE) || i_frame_start;
    assign w_dir   = w_first ? i_lsb_first : r_dir;
    assign w_base  = i_frame_start ? '0 : r_shreg;
    assign w_next  = w_dir ? {i_bit, w_base[N-1:1]} : {w_base[N-2:0], i_bit};

    // A frame-start bit is always bit 1, so it can never complete a word (N >= 2).
    assign w_last  = i_bit_valid && !i_frame_start && (r_count == LAST);
    assign w_drain = r_valid && i_ready;
    assign w_load  = w_last && (!r_valid || i_ready);
    assign w_drop  = w_last && r_valid && !i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_count   <= '0;
            r_dir     <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_bit_valid) begin
                r_shreg <= w_next;
                r_dir   <= w_dir;
            end else if (i_frame_start) begin
                r_shreg <= '0;
            end

            if (i_frame_start) begin
                r_count <= i_bit_valid ? CW'(1) : '0;
                r_state <= i_bit_valid ? RECV : IDLE;
            end else if (i_bit_valid) begin
                if (w_last) begin
                    r_count <= '0;
                    r_state <= IDLE;
                end else begin
                    r_count <= r_count + CW'(1);
                    r_state <= RECV;
                end
            end

            // A word loading on a drain edge keeps o_valid high.
            if (w_load) begin
                r_data  <= w_next;
                r_valid <= 1'b1;
            end else if (w_drain) begin
                r_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_clr_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_busy    = (r_count != '0);
    assign o_overrun = r_overrun;

endmodule
